// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the APB initiator.
//   apb_state_e : initiator FSM states
//   apb_rsp_t   : completed-transfer response (rdata, err, timeout)
// rdata is sized for the widest supported data bus (APB_RSP_DW); narrower
// initiators use the low APB_DW bits and keep the upper bits at zero.
package apb_pkg;

  localparam int unsigned APB_RSP_DW = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_RSP_DW-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus bundle.
//   master modport drives paddr/psel/penable/pwrite/pwdata/pstrb/pprot and
//   samples prdata/pready/pslverr; slave modport is the mirror image.
interface apb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts stalled ACCESS cycles.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (held while not in ACCESS)
//   enable     : this cycle is a stalled ACCESS cycle
//   expired    : this enabled cycle is the LIMIT-th stall; abort now
// LIMIT = 0 disables the timeout entirely.
module apb_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (LIMIT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (clear) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    // cnt_q holds the stalls already seen, so the current stall is number
    // cnt_q+1; firing combinationally keeps ACCESS at exactly LIMIT cycles.
    assign expired = enable && (cnt_q == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB master with valid/ready front end.
//   pclk, prst_n            : clock, async active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_addr/write/wdata/strb : request fields, registered on accept
//   rsp_valid/rsp_ready     : response handshake (valid only in RESP)
//   rsp_rdata/err/timeout   : response fields, stable while rsp_valid
//   m_apb                   : APB master port
// APB_DW must not exceed apb_pkg::APB_RSP_DW.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int unsigned APB_AW  = 32,
  parameter int unsigned APB_DW  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [APB_AW-1:0]   req_addr,
  input  logic                req_write,
  input  logic [APB_DW-1:0]   req_wdata,
  input  logic [APB_DW/8-1:0] req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [APB_DW-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  apb_if.master               m_apb
);

  apb_state_e          state_q, state_d;
  logic [APB_AW-1:0]   addr_q;
  logic                write_q;
  logic [APB_DW-1:0]   wdata_q;
  logic [APB_DW/8-1:0] strb_q;
  apb_rsp_t            rsp_q;
  logic                tmo_expired;
  logic                unused_rsp_bits;

  apb_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk     (pclk),
    .rst_n   (prst_n),
    .clear   (state_q != ST_ACCESS),
    .enable  ((state_q == ST_ACCESS) && !m_apb.pready),
    .expired (tmo_expired)
  );

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (m_apb.pready || tmo_expired) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    rsp_valid     = (state_q == ST_RESP);
    m_apb.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    m_apb.penable = (state_q == ST_ACCESS);
    m_apb.paddr   = addr_q;
    m_apb.pwrite  = write_q;
    m_apb.pwdata  = wdata_q;
    m_apb.pstrb   = strb_q;
    m_apb.pprot   = '0;
    rsp_rdata     = rsp_q.rdata[APB_DW-1:0];
    rsp_err       = rsp_q.err;
    rsp_timeout   = rsp_q.timeout;
  end

  // Bus fields and the response are only loaded at the accept and
  // completion points, which keeps them stable through ACCESS and RESP.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rsp_q   <= '0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
        strb_q  <= req_write ? req_strb : '0;
      end
      if (state_q == ST_ACCESS) begin
        if (m_apb.pready) begin
          rsp_q.rdata   <= write_q ? '0 : APB_RSP_DW'(m_apb.prdata);
          rsp_q.err     <= m_apb.pslverr;
          rsp_q.timeout <= 1'b0;
        end else if (tmo_expired) begin
          rsp_q.rdata   <= '0;
          rsp_q.err     <= 1'b1;
          rsp_q.timeout <= 1'b1;
        end
      end
    end
  end

  assign unused_rsp_bits = ^rsp_q.rdata;

endmodule

// File: tb/tb_apb_initiator.sv
module tb_apb_initiator;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          pclk = 1'b0;
  logic          prst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic [3:0]    req_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 pclk = ~pclk;

  apb_if #(.AW(AW), .DW(DW)) apb ();

  apb_initiator #(.APB_AW(AW), .APB_DW(DW), .TIMEOUT(TMO)) dut (
    .pclk        (pclk),
    .prst_n      (prst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .m_apb       (apb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random slave-side values; the initiator must ignore them outside ACCESS.
  task automatic slave_noise();
    apb.pready  = 1'($urandom_range(0, 1));
    apb.prdata  = $urandom;
    apb.pslverr = 1'($urandom_range(0, 1));
  endtask

  task automatic check_bus(input string ph, input logic [31:0] addr, input bit write,
                           input logic [31:0] wdata, input logic [3:0] strb, input bit pen);
    check({ph, "_psel"},    apb.psel, 1);
    check({ph, "_penable"}, apb.penable, pen);
    check({ph, "_paddr"},   apb.paddr, addr);
    check({ph, "_pwrite"},  apb.pwrite, write);
    check({ph, "_pwdata"},  apb.pwdata, wdata);
    check({ph, "_pstrb"},   apb.pstrb, write ? strb : 4'h0);
    check({ph, "_pprot"},   apb.pprot, 3'b000);
    check({ph, "_rsp_valid"}, rsp_valid, 0);
    check({ph, "_req_ready"}, req_ready, 0);
  endtask

  // One transfer, entered and left at a falling edge with the DUT in IDLE.
  // stall = pready-low ACCESS cycles the slave inserts before pready;
  // hold = cycles rsp_ready stays low; poke offers a request during RESP.
  task automatic xfer(input logic [31:0] addr, input bit write, input logic [31:0] wdata,
                      input logic [3:0] strb, input int unsigned stall,
                      input logic [31:0] rdata, input bit slverr,
                      input int unsigned hold, input bit poke);
    bit          tmo;
    int unsigned n_acc;
    logic [31:0] exp_rdata;
    bit          exp_err;
    tmo       = (TMO != 0) && (stall >= TMO);
    n_acc     = tmo ? TMO : stall + 1;
    exp_rdata = (write || tmo) ? 32'h0 : rdata;
    exp_err   = tmo || slverr;

    slave_noise();
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = write;
    req_wdata = wdata;
    req_strb  = strb;
    check("idle_req_ready", req_ready, 1);
    check("idle_rsp_valid", rsp_valid, 0);
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    slave_noise();
    check_bus("setup", addr, write, wdata, strb, 1'b0);

    for (int unsigned i = 0; i < n_acc; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      apb.pready  = !tmo && (i == stall);
      apb.prdata  = apb.pready ? rdata : $urandom;
      apb.pslverr = apb.pready ? slverr : 1'($urandom_range(0, 1));
      check_bus("access", addr, write, wdata, strb, 1'b1);
    end
    @(posedge pclk);
    @(negedge pclk);

    for (int unsigned h = 0; h <= hold; h++) begin
      slave_noise();
      check("resp_valid",   rsp_valid, 1);
      check("resp_rdata",   rsp_rdata, exp_rdata);
      check("resp_err",     rsp_err, exp_err);
      check("resp_timeout", rsp_timeout, tmo);
      check("resp_psel",    apb.psel, 0);
      check("resp_penable", apb.penable, 0);
      check("resp_req_ready", req_ready, 0);
      rsp_ready = (h == hold);
      if (poke) begin
        req_valid = 1'b1;
        req_addr  = $urandom;
        req_write = 1'($urandom_range(0, 1));
      end
      @(posedge pclk);
      @(negedge pclk);
    end
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_req_ready", req_ready, 1);
    check("done_psel", apb.psel, 0);
    req_valid = 1'b0;
  endtask

  task automatic reset_mid_access();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_write = 1'b1;
    req_wdata = 32'hCAFE_F00D;
    req_strb  = 4'h3;
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge pclk);
      @(negedge pclk);
      apb.pready = 1'b0;
      check("rst_pre_penable", apb.penable, 1);
    end
    prst_n = 1'b0;
    #1;
    check("rst_psel",      apb.psel, 0);
    check("rst_penable",   apb.penable, 0);
    check("rst_paddr",     apb.paddr, 0);
    check("rst_pstrb",     apb.pstrb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    check("rst_hold_rsp_valid", rsp_valid, 0);
    prst_n = 1'b1;
    @(negedge pclk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_psel",      apb.psel, 0);
  endtask

  initial begin
    prst_n      = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_write   = 1'b0;
    req_wdata   = '0;
    req_strb    = '0;
    rsp_ready   = 1'b0;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    check("reset_psel",        apb.psel, 0);
    check("reset_penable",     apb.penable, 0);
    check("reset_paddr",       apb.paddr, 0);
    check("reset_pwdata",      apb.pwdata, 0);
    check("reset_pstrb",       apb.pstrb, 0);
    check("reset_pwrite",      apb.pwrite, 0);
    check("reset_rsp_valid",   rsp_valid, 0);
    check("reset_rsp_rdata",   rsp_rdata, 0);
    check("reset_rsp_err",     rsp_err, 0);
    check("reset_rsp_timeout", rsp_timeout, 0);
    check("reset_req_ready",   req_ready, 1);
    prst_n = 1'b1;
    @(negedge pclk);

    // Zero-wait write
    xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
    // Read with three wait states
    xfer(32'h04, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
    // Read with slave error
    xfer(32'h08, 1'b0, 32'h0, 4'h0, 1, 32'hAABB_CCDD, 1'b1, 0, 1'b0);
    // Slave never ready: timeout
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, 1000, 32'h5555_AAAA, 1'b0, 0, 1'b0);
    // pready on the last stall-allowed cycle completes normally
    xfer(32'h14, 1'b0, 32'h0, 4'h0, TMO - 1, 32'h0F0F_0F0F, 1'b0, 0, 1'b0);
    // One more stall than allowed: write timeout
    xfer(32'h18, 1'b1, 32'h1111_2222, 4'h5, TMO, 32'h0, 1'b0, 0, 1'b0);
    // Response back-pressure with a request waiting, then back-to-back
    xfer(32'h20, 1'b0, 32'h0, 4'h0, 0, 32'hA5A5_5A5A, 1'b0, 5, 1'b1);
    xfer(32'h24, 1'b1, 32'h7777_8888, 4'hC, 0, 32'h0, 1'b1, 0, 1'b0);
    xfer(32'h28, 1'b0, 32'h0, 4'h0, 2, 32'h9999_0000, 1'b0, 0, 1'b0);
    // Reset in the middle of ACCESS, then a normal transfer
    reset_mid_access();
    xfer(32'h30, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      xfer($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
           $urandom_range(0, TMO + 4), $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter APB_AW, default 32, APB address width.
REQ-002 SHALL have parameter APB_DW, default 32, APB data width; APB_DW/8 strobe bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS-phase wait cycles; 0 disables timeout.
REQ-004 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port prst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request offered.
REQ-007 SHALL have port req_ready  output  1  request accepted when both high.
REQ-008 SHALL have port req_addr  input  APB_AW  target address.
REQ-009 SHALL have port req_write  input  1  1=write, 0=read.
REQ-010 SHALL have port req_wdata  input  APB_DW  write data.
REQ-011 SHALL have port req_strb  input  APB_DW/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when both high.
REQ-014 SHALL have port rsp_rdata  output  APB_DW  read data; 0 for writes and timeouts.
REQ-015 SHALL have port rsp_err  output  1  PSLVERR seen or timeout.
REQ-016 SHALL have port rsp_timeout  output  1  transfer aborted by timeout.
REQ-017 SHALL have port m_apb  interface  APB master modport  drives paddr, psel, penable, pwrite, pwdata, pstrb, pprot; samples prdata, pready, pslverr.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-019 SHALL assert req_ready only in IDLE.
REQ-020 SHALL, on req_valid&&req_ready, register addr/write/wdata/strb and enter SETUP next cycle.
REQ-021 SHALL in SETUP drive psel=1, penable=0, registered fields on APB; next state ACCESS unconditionally.
REQ-022 SHALL in ACCESS drive psel=1, penable=1, all APB outputs stable until completion.
REQ-023 SHALL complete ACCESS on cycle with pready=1: capture prdata (reads only) and pslverr, enter RESP; psel/penable low from next cycle.
REQ-024 SHALL drive pstrb=0 during reads; pprot fixed 3'b000.
REQ-025 SHALL count ACCESS cycles with pready=0; when count reaches TIMEOUT (TIMEOUT>0) abort: enter RESP, rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel/penable low next cycle.
REQ-026 SHALL give pready priority over timeout if both occur in the same cycle.
REQ-027 SHALL hold rsp_valid=1 and response fields stable in RESP until rsp_ready=1, then enter IDLE; no new request accepted same cycle.
REQ-028 SHALL yield minimum request-accept-to-rsp_valid latency of 3 cycles (SETUP, ACCESS with pready, RESP).
REQ-029 SHALL ignore pready/pslverr/prdata outside ACCESS.
REQ-030 SHALL keep only one transfer outstanding.

Reset
REQ-031 SHALL on prst_n=0 asynchronously force state IDLE, psel=0, penable=0, paddr=0, pwdata=0, pstrb=0, pwrite=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter 0.
REQ-032 SHALL abandon any in-flight transfer on reset without emitting a response.

Structure
REQ-033 SHALL take state enum and response struct (rdata, err, timeout) from shared package apb_pkg.
REQ-034 SHALL place timeout counter in sub-module apb_timeout_cnt (clear, enable, expired).

Verification
REQ-035 SHALL verify write addr 0x10 data 0xDEADBEEF strb 0xF, pready=1 -> psel in cycle+1, penable cycle+2, rsp_valid cycle+3, rsp_err=0.
REQ-036 SHALL verify read addr 0x04, pready low 3 ACCESS cycles, prdata=0x12345678 -> APB signals stable 4 ACCESS cycles, rsp_rdata=0x12345678.
REQ-037 SHALL verify read with pslverr=1 on pready cycle -> rsp_err=1, rsp_timeout=0.
REQ-038 SHALL verify TIMEOUT=16, pready never high -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-039 SHALL verify rsp_ready low 5 cycles then high -> rsp fields stable, req_ready low until IDLE; back-to-back requests then both complete in order.
REQ-040 SHALL verify prst_n low mid-ACCESS -> psel/penable 0 immediately, no rsp_valid, next request after reset completes normally.
